// File: rtl/zx_kbd_pkg.sv
// Shared scancodes, matrix positions and lookup helpers for the ZX Spectrum
// PS/2 keyboard front end.
package zx_kbd_pkg;

  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_AA     = 8'hAA;

  localparam logic [7:0] SC_FK1    = 8'h05;
  localparam logic [7:0] SC_FK2    = 8'h06;
  localparam logic [7:0] SC_FK3    = 8'h04;
  localparam logic [7:0] SC_FK4    = 8'h0C;
  localparam logic [7:0] SC_FK5    = 8'h03;
  localparam logic [7:0] SC_FK6    = 8'h0B;
  localparam logic [7:0] SC_FK7    = 8'h83;
  localparam logic [7:0] SC_FK8    = 8'h0A;
  localparam logic [7:0] SC_FK9    = 8'h01;
  localparam logic [7:0] SC_FK10   = 8'h09;
  localparam logic [7:0] SC_FK11   = 8'h78;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_RIGHT  = 8'h74;

  localparam logic [2:0] ROW_CS  = 3'd0;
  localparam logic [2:0] BIT_CS  = 3'd0;
  localparam logic [2:0] ROW_SS  = 3'd7;
  localparam logic [2:0] BIT_SS  = 3'd1;
  localparam logic [2:0] ROW_D15 = 3'd3;
  localparam logic [2:0] ROW_D60 = 3'd4;
  localparam logic [2:0] BIT_K5  = 3'd4;
  localparam logic [2:0] BIT_K0  = 3'd0;
  localparam logic [2:0] BIT_K8  = 3'd2;
  localparam logic [2:0] BIT_K7  = 3'd3;
  localparam logic [2:0] BIT_K6  = 3'd4;

  localparam int CMP_BKSP  = 0;
  localparam int CMP_LEFT  = 1;
  localparam int CMP_DOWN  = 2;
  localparam int CMP_UP    = 3;
  localparam int CMP_RIGHT = 4;

  typedef logic [7:0][4:0] kbd_matrix_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] row;
    logic [2:0] col;
  } key_pos_t;

  function automatic key_pos_t kp(input int r, input int c);
    key_pos_t p;
    p.hit = 1'b1;
    p.row = 3'(r);
    p.col = 3'(c);
    return p;
  endfunction

  // Plain (non-E0) scancodes that land directly on one matrix position
  function automatic key_pos_t map_key(input logic [7:0] code);
    key_pos_t p;
    p = '0;
    case (code)
      8'h12: p = kp(0, 0);  8'h1A: p = kp(0, 1);  8'h22: p = kp(0, 2);
      8'h21: p = kp(0, 3);  8'h2A: p = kp(0, 4);
      8'h1C: p = kp(1, 0);  8'h1B: p = kp(1, 1);  8'h23: p = kp(1, 2);
      8'h2B: p = kp(1, 3);  8'h34: p = kp(1, 4);
      8'h15: p = kp(2, 0);  8'h1D: p = kp(2, 1);  8'h24: p = kp(2, 2);
      8'h2D: p = kp(2, 3);  8'h2C: p = kp(2, 4);
      8'h16: p = kp(3, 0);  8'h1E: p = kp(3, 1);  8'h26: p = kp(3, 2);
      8'h25: p = kp(3, 3);  8'h2E: p = kp(3, 4);
      8'h45: p = kp(4, 0);  8'h46: p = kp(4, 1);  8'h3E: p = kp(4, 2);
      8'h3D: p = kp(4, 3);  8'h36: p = kp(4, 4);
      8'h4D: p = kp(5, 0);  8'h44: p = kp(5, 1);  8'h43: p = kp(5, 2);
      8'h3C: p = kp(5, 3);  8'h35: p = kp(5, 4);
      8'h5A: p = kp(6, 0);  8'h4B: p = kp(6, 1);  8'h42: p = kp(6, 2);
      8'h3B: p = kp(6, 3);  8'h33: p = kp(6, 4);
      8'h29: p = kp(7, 0);  8'h59: p = kp(7, 1);  8'h3A: p = kp(7, 2);
      8'h31: p = kp(7, 3);  8'h32: p = kp(7, 4);
      default: p = '0;
    endcase
    return p;
  endfunction

  // Function key number 1..11, or 0 when the code is not a function key
  function automatic logic [3:0] fn_index(input logic [7:0] code);
    case (code)
      SC_FK1:  return 4'd1;
      SC_FK2:  return 4'd2;
      SC_FK3:  return 4'd3;
      SC_FK4:  return 4'd4;
      SC_FK5:  return 4'd5;
      SC_FK6:  return 4'd6;
      SC_FK7:  return 4'd7;
      SC_FK8:  return 4'd8;
      SC_FK9:  return 4'd9;
      SC_FK10: return 4'd10;
      SC_FK11: return 4'd11;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: line synchronizers, clock glitch filter, frame FSM
// and stall timeout. Emits a one-cycle o_byte_valid per good frame.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | waiting for a start bit (data low on strobe)
// ST_DATA  | shifting 8 data bits, LSB first
// ST_PAR   | capturing the odd-parity bit
// ST_STOP  | checking stop bit and parity, then idle
module ps2_rx #(
  parameter int          FILTER_LEN = 8,
  parameter logic [15:0] TIMEOUT    = 16'd50000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_byte_valid,
  output logic [7:0] o_byte
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_PAR  = 2'd2;
  localparam logic [1:0] ST_STOP = 2'd3;

  localparam logic [7:0]  FLT_RELOAD = 8'(FILTER_LEN - 1);
  localparam logic [15:0] TMO_RELOAD = TIMEOUT - 16'd1;

  logic       r_clk_meta, r_clk_s, r_dat_meta, r_dat_s;
  logic       r_filt;
  logic [7:0] r_fcnt;
  logic       w_fall;

  logic [1:0]  r_state;
  logic [2:0]  r_cnt;
  logic [7:0]  r_shift;
  logic        r_par;
  logic [15:0] r_tmo;
  logic        r_valid;
  logic [7:0]  r_byte;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_clk_meta <= 1'b1;
      r_clk_s    <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_s    <= 1'b1;
    end else begin
      r_clk_meta <= i_ps2_clk;
      r_clk_s    <= r_clk_meta;
      r_dat_meta <= i_ps2_data;
      r_dat_s    <= r_dat_meta;
    end
  end

  // Filtered clock follows only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_filt <= 1'b1;
      r_fcnt <= FLT_RELOAD;
    end else if (r_clk_s == r_filt) begin
      r_fcnt <= FLT_RELOAD;
    end else if (r_fcnt == 8'd0) begin
      r_filt <= r_clk_s;
      r_fcnt <= FLT_RELOAD;
    end else begin
      r_fcnt <= r_fcnt - 8'd1;
    end
  end

  assign w_fall = r_filt & ~r_clk_s & (r_fcnt == 8'd0);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_tmo <= '0;
    end else if (w_fall) begin
      r_tmo <= TMO_RELOAD;
    end else if (r_tmo != 16'd0) begin
      r_tmo <= r_tmo - 16'd1;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_valid <= 1'b0;
      r_byte  <= '0;
    end else begin
      r_valid <= 1'b0;
      if (w_fall) begin
        case (r_state)
          ST_IDLE: begin
            if (!r_dat_s) begin
              r_state <= ST_DATA;
              r_cnt   <= '0;
            end
          end
          ST_DATA: begin
            r_shift <= {r_dat_s, r_shift[7:1]};
            r_cnt   <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) r_state <= ST_PAR;
          end
          ST_PAR: begin
            r_par   <= r_dat_s;
            r_state <= ST_STOP;
          end
          default: begin
            if (r_dat_s && (^{r_shift, r_par})) begin
              r_valid <= 1'b1;
              r_byte  <= r_shift;
            end
            r_state <= ST_IDLE;
          end
        endcase
      end else if (r_state != ST_IDLE && r_tmo == 16'd0) begin
        r_state <= ST_IDLE;
      end
    end
  end

  assign o_byte_valid = r_valid;
  assign o_byte       = r_byte;

endmodule

// File: rtl/zx_ps2_keyboard.sv
// PS/2 keyboard to ZX Spectrum 8x5 matrix, function keys and modifier levels.
// key_data is combinational from addr so the CPU sees it within the read cycle.
module zx_ps2_keyboard
  import zx_kbd_pkg::*;
#(
  parameter int          FILTER_LEN = 8,
  parameter logic [15:0] TIMEOUT    = 16'd50000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_kbd_clk,
  input  logic        ps2_kbd_data,
  input  logic [15:0] addr,
  output logic [4:0]  key_data,
  output logic [11:1] Fn,
  output logic [2:0]  mod
);

  logic       w_valid;
  logic [7:0] w_byte;

  ps2_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT)
  ) u_rx (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .i_ps2_clk    (ps2_kbd_clk),
    .i_ps2_data   (ps2_kbd_data),
    .o_byte_valid (w_valid),
    .o_byte       (w_byte)
  );

  kbd_matrix_t r_matrix;
  logic [4:0]  r_comp;
  logic [11:1] r_fn;
  logic        r_lctrl, r_rctrl, r_lalt, r_ralt;
  logic        r_rel, r_ext;

  key_pos_t    w_pos;
  logic [3:0]  w_fn_idx;
  kbd_matrix_t w_key_mask;
  logic [11:1] w_fn_mask;
  logic [4:0]  w_comp_mask;

  // Only plain codes hit the direct matrix and Fn; E0 codes only reach arrows
  always_comb begin
    w_pos       = map_key(w_byte);
    w_fn_idx    = fn_index(w_byte);
    w_key_mask  = '0;
    w_fn_mask   = '0;
    w_comp_mask = '0;
    if (!r_ext) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 5; c++)
          if (w_pos.hit && w_pos.row == 3'(r) && w_pos.col == 3'(c))
            w_key_mask[r][c] = 1'b1;
      for (int i = 1; i <= 11; i++)
        if (w_fn_idx == 4'(i)) w_fn_mask[i] = 1'b1;
      if (w_byte == SC_BKSP) w_comp_mask[CMP_BKSP] = 1'b1;
    end else begin
      case (w_byte)
        SC_LEFT:  w_comp_mask[CMP_LEFT]  = 1'b1;
        SC_DOWN:  w_comp_mask[CMP_DOWN]  = 1'b1;
        SC_UP:    w_comp_mask[CMP_UP]    = 1'b1;
        SC_RIGHT: w_comp_mask[CMP_RIGHT] = 1'b1;
        default:  w_comp_mask = '0;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_matrix <= '0;
      r_comp   <= '0;
      r_fn     <= '0;
      r_lctrl  <= 1'b0;
      r_rctrl  <= 1'b0;
      r_lalt   <= 1'b0;
      r_ralt   <= 1'b0;
      r_rel    <= 1'b0;
      r_ext    <= 1'b0;
    end else if (w_valid) begin
      if (w_byte == SC_F0) begin
        r_rel <= 1'b1;
      end else if (w_byte == SC_E0) begin
        r_ext <= 1'b1;
      end else if (w_byte == SC_E1 || w_byte == SC_AA) begin
      end else begin
        r_matrix <= r_rel ? (r_matrix & ~w_key_mask) : (r_matrix | w_key_mask);
        r_comp   <= r_rel ? (r_comp & ~w_comp_mask) : (r_comp | w_comp_mask);
        r_fn     <= r_rel ? (r_fn & ~w_fn_mask) : (r_fn | w_fn_mask);
        if (w_byte == SC_CTRL) begin
          if (r_ext) r_rctrl <= ~r_rel;
          else       r_lctrl <= ~r_rel;
        end
        if (w_byte == SC_ALT) begin
          if (r_ext) r_ralt <= ~r_rel;
          else       r_lalt <= ~r_rel;
        end
        r_rel <= 1'b0;
        r_ext <= 1'b0;
      end
    end
  end

  kbd_matrix_t w_pressed;
  logic [4:0]  w_col;

  always_comb begin
    w_pressed = r_matrix;
    w_pressed[ROW_CS][BIT_CS]  = r_matrix[ROW_CS][BIT_CS] | (|r_comp);
    w_pressed[ROW_D60][BIT_K0] = r_matrix[ROW_D60][BIT_K0] | r_comp[CMP_BKSP];
    w_pressed[ROW_D15][BIT_K5] = r_matrix[ROW_D15][BIT_K5] | r_comp[CMP_LEFT];
    w_pressed[ROW_D60][BIT_K6] = r_matrix[ROW_D60][BIT_K6] | r_comp[CMP_DOWN];
    w_pressed[ROW_D60][BIT_K7] = r_matrix[ROW_D60][BIT_K7] | r_comp[CMP_UP];
    w_pressed[ROW_D60][BIT_K8] = r_matrix[ROW_D60][BIT_K8] | r_comp[CMP_RIGHT];
    w_col = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        w_col[c] = w_col[c] | (w_pressed[r][c] & ~addr[8+r]);
  end

  logic w_unused_addr_lo;
  assign w_unused_addr_lo = ^addr[7:0];

  assign key_data = ~w_col;
  assign Fn       = r_fn;
  assign mod      = {r_matrix[ROW_CS][BIT_CS] | r_matrix[ROW_SS][BIT_SS],
                     r_lctrl | r_rctrl,
                     r_lalt | r_ralt};

endmodule

// File: tb/tb_zx_ps2_keyboard.sv
// Directed bench for zx_ps2_keyboard: serial PS/2 frames in, matrix/Fn/mod
// levels checked against hand-computed values.
module tb_zx_ps2_keyboard;

  localparam int          HALF = 20;
  localparam logic [15:0] TMO  = 16'd1000;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_kbd_clk = 1'b1;
  logic        ps2_kbd_data = 1'b1;
  logic [15:0] addr = 16'hFFFF;
  logic [4:0]  key_data;
  logic [11:1] Fn;
  logic [2:0]  mod;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_sys = ~clk_sys;

  zx_ps2_keyboard #(
    .FILTER_LEN (8),
    .TIMEOUT    (TMO)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ps2_kbd_clk  (ps2_kbd_clk),
    .ps2_kbd_data (ps2_kbd_data),
    .addr         (addr),
    .key_data     (key_data),
    .Fn           (Fn),
    .mod          (mod)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_kbd_data = b;
    repeat (HALF) @(posedge clk_sys);
    ps2_kbd_clk = 1'b0;
    repeat (HALF) @(posedge clk_sys);
    ps2_kbd_clk = 1'b1;
  endtask

  task automatic ps2_frame(input logic [7:0] code, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit((~^code) ^ bad_par);
    ps2_bit(1'b1);
    ps2_kbd_data = 1'b1;
    repeat (HALF) @(posedge clk_sys);
  endtask

  task automatic send(input logic [7:0] code);
    ps2_frame(code, 1'b0);
  endtask

  task automatic brk(input logic [7:0] code);
    send(8'hF0);
    send(code);
  endtask

  task automatic kd(input string tag, input logic [15:0] a, input logic [4:0] exp);
    @(negedge clk_sys);
    addr = a;
    #1;
    check(tag, {11'b0, key_data}, {11'b0, exp});
  endtask

  task automatic lv(input string tag, input logic [2:0] exp_mod, input logic [11:1] exp_fn);
    @(negedge clk_sys);
    check({tag, "_mod"}, {13'b0, mod}, {13'b0, exp_mod});
    check({tag, "_fn"}, {5'b0, Fn}, {5'b0, exp_fn});
  endtask

  initial begin
    repeat (10) @(posedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (20) @(posedge clk_sys);

    kd("idle_row0", 16'hFEFE, 5'b11111);
    kd("idle_all", 16'h00FE, 5'b11111);
    lv("idle", 3'b000, 11'h000);

    send(8'h1C);
    kd("make_a", 16'hFDFE, 5'b11110);
    brk(8'h1C);
    kd("break_a", 16'hFDFE, 5'b11111);

    send(8'h12);
    send(8'h1A);
    kd("merge_all", 16'h00FE, 5'b11100);
    kd("merge_r0", 16'hFEFE, 5'b11100);
    kd("merge_r7", 16'h7FFE, 5'b11111);
    lv("lshift", 3'b100, 11'h000);
    brk(8'h12);
    brk(8'h1A);
    lv("shift_off", 3'b000, 11'h000);
    send(8'h59);
    kd("rshift_r7", 16'h7FFE, 5'b11101);
    lv("rshift", 3'b100, 11'h000);
    brk(8'h59);

    send(8'h66);
    send(8'h45);
    kd("bksp_cs", 16'hFEFE, 5'b11110);
    kd("bksp_r4", 16'hEFFE, 5'b11110);
    brk(8'h66);
    kd("bksp_rel_r4", 16'hEFFE, 5'b11110);
    kd("bksp_rel_cs", 16'hFEFE, 5'b11111);
    brk(8'h45);
    kd("zero_rel", 16'hEFFE, 5'b11111);

    send(8'hE0); send(8'h75);
    kd("up_r4", 16'hEFFE, 5'b10111);
    kd("up_cs", 16'hFEFE, 5'b11110);
    send(8'hE0); brk(8'h75);
    kd("up_rel", 16'hEEFE, 5'b11111);
    send(8'hE0); send(8'h74);
    kd("right_r4", 16'hEFFE, 5'b11011);
    send(8'hE0); brk(8'h74);
    send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'h72);
    kd("left_r3", 16'hF7FE, 5'b01111);
    kd("down_r4", 16'hEFFE, 5'b01111);
    send(8'hE0); brk(8'h6B);
    send(8'hE0); brk(8'h72);
    kd("arrows_rel", 16'h00FE, 5'b11111);

    send(8'h12);
    send(8'h66);
    brk(8'h66);
    kd("cs_direct_kept", 16'hFEFE, 5'b11110);
    brk(8'h12);
    kd("cs_direct_rel", 16'hFEFE, 5'b11111);

    send(8'h14);
    send(8'h78);
    lv("ctrl_f11", 3'b010, 11'h400);
    brk(8'h78);
    lv("f11_rel", 3'b010, 11'h000);
    send(8'h83);
    lv("f7", 3'b010, 11'h040);
    brk(8'h83);
    brk(8'h14);
    lv("ctrl_rel", 3'b000, 11'h000);

    send(8'hE0); send(8'h11);
    lv("ralt", 3'b001, 11'h000);
    send(8'h11);
    send(8'hE0); brk(8'h11);
    lv("lalt_kept", 3'b001, 11'h000);
    brk(8'h11);
    lv("alt_rel", 3'b000, 11'h000);

    send(8'h1C);
    send(8'h1C);
    brk(8'h1B);
    kd("typematic", 16'hFDFE, 5'b11110);
    send(8'hF0); send(8'hAA); send(8'h1C);
    kd("aa_ignored", 16'hFDFE, 5'b11111);

    ps2_frame(8'h1C, 1'b1);
    kd("bad_parity", 16'hFDFE, 5'b11111);

    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    ps2_kbd_data = 1'b1;
    repeat (int'(TMO) + 200) @(posedge clk_sys);
    send(8'h1C);
    kd("after_timeout", 16'hFDFE, 5'b11110);

    send(8'h14);
    send(8'h05);
    kd("pre_rst_kd", 16'h0000, 5'b11110);
    lv("pre_rst", 3'b010, 11'h001);
    ps2_bit(1'b0);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b1);
    @(negedge clk_sys);
    #1;
    reset = 1'b1;
    #1;
    check("rst_kd", {11'b0, key_data}, 16'h001F);
    check("rst_mod", {13'b0, mod}, 16'h0000);
    check("rst_fn", {5'b0, Fn}, 16'h0000);
    repeat (5) @(posedge clk_sys);
    @(negedge clk_sys);
    ps2_kbd_data = 1'b1;
    reset = 1'b0;
    repeat (50) @(posedge clk_sys);
    kd("post_rst_clear", 16'h0000, 5'b11111);
    send(8'h1C);
    kd("post_rst_a", 16'hFDFE, 5'b11110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
